// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path.
//   - send-sequencer state encoding (IDLE / SEND / WAIT / GAP)
//   - baud divisors for a 50 MHz clock (terminal count, i.e. divide-by minus 1)
//   - frame length (start + 8 data + parity + stop = 11 bit times)
//   - watchdog counter width and a helper that gives the clock cycles one
//     frame occupies at a given divisor
//   No ports; import with `import uart_pkg::*;`.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a byte and an idle transmitter
        ST_SEND = 2'd1,   // one-cycle send request
        ST_WAIT = 2'd2,   // waiting for tx_done, watchdog running
        ST_GAP  = 2'd3    // enforced idle time between frames
    } tx_state_t;

    // Baud divisor terminal counts at 50 MHz.
    localparam int DIV_9600   = 5207;
    localparam int DIV_19200  = 2603;
    localparam int DIV_38400  = 1301;
    localparam int DIV_57600  = 867;
    localparam int DIV_115200 = 433;

    localparam int FRAME_BITS = 11;

    // Watchdog width: must hold the longest frame at the slowest baud rate.
    localparam int WDOG_W = 17;

    // Clock cycles taken by one complete frame for a given divisor.
    function automatic int frame_cycles(input int div);
        return FRAME_BITS * (div + 1);
    endfunction

    // Longest frame the transmitter can produce; a watchdog timeout must
    // exceed this or a healthy slow frame would be aborted.
    localparam int MAX_FRAME_CYC = frame_cycles(DIV_9600);

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock byte FIFO with registered read data and registered status.
//   A write is accepted only when the registered full flag is low; a read is
//   accepted only when the registered empty flag is low. Read data updates
//   only on an accepted read and holds otherwise.
//
//   Parameters
//     DEPTH    number of entries, power of two, >= 2
//     ADDR_W   log2(DEPTH)
//   Ports
//     clk      clock
//     reset    asynchronous, active-high reset
//     wr_en    write strobe, one byte per high cycle
//     wr_data  byte to write
//     rd_en    read strobe
//     rd_data  registered read data, holds between reads
//     count    occupancy 0..DEPTH
//     full     registered, count == DEPTH
//     empty    registered, count == 0
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;
    logic [ADDR_W:0]   count_next;

    // Gated by the registered flags, so a write while full is dropped even if
    // a read frees a slot in the same cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CNT_ONE;
        end else if (!wr_ok && rd_ok) begin
            count_next = count - CNT_ONE;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
            empty <= (count_next == '0);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count already
    // make stale entries unreachable, and a reset on the array would stop it
    // mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
//   Byte FIFO plus send sequencer in front of the UART byte transmitter.
//   Bytes arrive in bursts from a producer; each is handed to the transmitter
//   with a one-cycle send request, and the next byte is held back until the
//   transmitter reports completion (plus an optional idle gap). A watchdog
//   aborts the wait if the completion pulse never comes.
//
//   Parameters
//     DEPTH     FIFO entries, power of two, >= 2
//     ADDR_W    log2(DEPTH)
//     GAP_CYC   idle cycles between tx_done and the next pop (0 = none)
//     TMO_CYC   cycles allowed in WAIT before abort; must exceed the longest
//               frame (uart_pkg::MAX_FRAME_CYC) and fit the 17-bit watchdog
//   Ports
//     clk           clock (50 MHz)
//     reset         asynchronous, active-high reset
//     wr_data       byte to enqueue
//     wr_en         enqueue strobe, one byte per high cycle
//     full          FIFO full (registered)
//     empty         FIFO empty (registered)
//     count         occupancy 0..DEPTH
//     overflow      sticky: a write was dropped because the FIFO was full
//     ovf_clr       clears overflow and tmo (a same-cycle set wins)
//     tmo           sticky: watchdog fired
//     tx_data_byte  byte to the transmitter, changes only on a pop
//     tx_send_en    one-cycle send request
//     tx_done       one-cycle completion pulse from the transmitter
//     tx_busy       transmitter busy; sampled only in IDLE
// -----------------------------------------------------------------------------
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              tmo,
    output logic [7:0]        tx_data_byte,
    output logic              tx_send_en,
    input  logic              tx_done,
    input  logic              tx_busy
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TMO_CYC - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic              pop;
    logic              wdog_fire;
    logic              gap_last;
    logic [WDOG_W-1:0] wdog;
    logic [GAP_W-1:0]  gap_cnt;

    // ------------------------------------------------------------------
    // Storage. The FIFO's registered read port is the transmit byte
    // register, so tx_data_byte moves only when a byte is popped.
    // ------------------------------------------------------------------
    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (tx_data_byte),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Completion has priority over a timeout landing in the same cycle.
    assign wdog_fire = (state == ST_WAIT) && !tx_done && (wdog == WDOG_LAST);
    assign gap_last  = (gap_cnt == GAP_LAST);

    // ------------------------------------------------------------------
    // Send sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_send_en = 1'b0;
        case (state)
            ST_IDLE: begin
                // tx_busy guards against talking over a frame still being
                // shifted out after this block alone was reset.
                if (!empty && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_send_en = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_next = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end else if (wdog_fire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog: cleared while sending, counts only in WAIT, saturates.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
        end else if (state == ST_SEND) begin
            wdog <= '0;
        end else if ((state == ST_WAIT) && (wdog != '1)) begin
            wdog <= wdog + WDOG_ONE;
        end
    end

    // Gap counter: held at zero outside GAP so each gap starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state != ST_GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status. A set in the same cycle as ovf_clr wins so an event
    // is never lost to a concurrent clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (wdog_fire) begin
                tmo <= 1'b1;
            end else if (ovf_clr) begin
                tmo <= 1'b0;
            end
        end
    end

endmodule
